// File: rtl/ahb_read_unpack_fifo.sv
// -----------------------------------------------------------------------------
// ahb_read_unpack_fifo
//
// Read-side buffer between the AHB master read path and the pixel datapath.
// Up to DEPTH bus words captured from HRDATA are queued and then unpacked into
// a byte stream on data_in, one byte per qualified shift. The byte order inside
// a word is selected by BYTE_ORDER (0 = LSB first, 1 = MSB first).
//
// Parameters:
//   DATA_W      bus word width in bits (multiple of 8, >= 16)
//   DEPTH       word storage depth (power of 2, >= 2)
//   BYTE_ORDER  0 = least-significant byte first, 1 = most-significant first
//
// Ports:
//   HCLK                      in   system clock, rising edge
//   HRESETn                   in   asynchronous active-low reset
//   status[1:0]               in   2'b10 = consumer ready, else shifting stalls
//   load_enable               in   capture HRDATA into the tail slot
//   HRDATA[DATA_W-1:0]        in   AHB read data word
//   shift_enable              in   request the next byte
//   clear                     in   synchronous flush (beats load and shift)
//   data_in[7:0]              out  registered output byte
//   data_valid                out  one-cycle pulse, data_in updated
//   full                      out  level == DEPTH
//   empty                     out  level == 0
//   level[clog2(DEPTH):0]     out  stored words, incl. partially consumed head
//   overflow                  out  sticky, a load was dropped
//   transfer_data_complete_r  out  one-cycle pulse when the FIFO drains
// -----------------------------------------------------------------------------
module ahb_read_unpack_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int BYTE_ORDER = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [1:0]               status,
    input  logic                     load_enable,
    input  logic [DATA_W-1:0]        HRDATA,
    input  logic                     shift_enable,
    input  logic                     clear,
    output logic [7:0]               data_in,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     transfer_data_complete_r
);

    localparam int BYTES = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(BYTES);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int SH_W  = IDX_W + 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    // Bit offset of the most-significant byte; fits in SH_W because BYTES-1 < 2**IDX_W.
    localparam logic [SH_W-1:0]  MSB_SH   = SH_W'(DATA_W - 8);

    // Pick byte number idx of a word in stream order.
    function automatic logic [7:0] select_byte(input logic [DATA_W-1:0] word,
                                               input logic [IDX_W-1:0]  idx);
        logic [DATA_W-1:0] shifted;
        logic [SH_W-1:0]   sh;
        sh = {idx, 3'b000};
        if (BYTE_ORDER == 0) begin
            shifted = word >> sh;
        end else begin
            shifted = word >> (MSB_SH - sh);
        end
        return shifted[7:0];
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [IDX_W-1:0]  byte_idx_r;

    logic              shift_s;
    logic              pop_s;
    logic              load_s;
    logic              drop_s;
    logic              complete_s;
    logic [LVL_W-1:0]  level_next_s;
    logic [7:0]        head_byte_s;

    // All qualifiers use pre-edge state; empty is registered, so a word loaded
    // into an empty FIFO can never be shifted in the same cycle.
    assign shift_s     = shift_enable & (status == 2'b10) & ~empty;
    assign pop_s       = shift_s & (byte_idx_r == LAST_IDX);
    // A full FIFO still accepts a word when the head word leaves this cycle.
    assign load_s      = load_enable & (~full | pop_s);
    assign drop_s      = load_enable & ~load_s;
    assign complete_s  = pop_s & ~load_s & (level == LVL_ONE);
    assign head_byte_s = select_byte(mem_r[rd_ptr_r], byte_idx_r);

    // Next word count from the qualified load and pop of this cycle.
    always_comb begin
        level_next_s = level;
        case ({load_s, pop_s})
            2'b10:   level_next_s = level + LVL_ONE;
            2'b01:   level_next_s = level - LVL_ONE;
            default: level_next_s = level;
        endcase
    end

    // Word storage; contents are don't-care after reset or flush.
    always_ff @(posedge HCLK) begin
        if (load_s && !clear) begin
            mem_r[wr_ptr_r] <= HRDATA;
        end
    end

    // Pointers, byte index, flags and registered outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_r                 <= {PTR_W{1'b0}};
            rd_ptr_r                 <= {PTR_W{1'b0}};
            byte_idx_r               <= {IDX_W{1'b0}};
            level                    <= LVL_ZERO;
            full                     <= 1'b0;
            empty                    <= 1'b1;
            overflow                 <= 1'b0;
            data_in                  <= 8'h00;
            data_valid               <= 1'b0;
            transfer_data_complete_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r                 <= {PTR_W{1'b0}};
            rd_ptr_r                 <= {PTR_W{1'b0}};
            byte_idx_r               <= {IDX_W{1'b0}};
            level                    <= LVL_ZERO;
            full                     <= 1'b0;
            empty                    <= 1'b1;
            overflow                 <= 1'b0;
            data_in                  <= 8'h00;
            data_valid               <= 1'b0;
            transfer_data_complete_r <= 1'b0;
        end else begin
            level                    <= level_next_s;
            full                     <= (level_next_s == FULL_LVL);
            empty                    <= (level_next_s == LVL_ZERO);
            transfer_data_complete_r <= complete_s;

            if (drop_s) begin
                overflow <= 1'b1;
            end

            if (load_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end

            if (shift_s) begin
                data_in    <= head_byte_s;
                data_valid <= 1'b1;
                if (pop_s) begin
                    byte_idx_r <= {IDX_W{1'b0}};
                    rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                end else begin
                    byte_idx_r <= byte_idx_r + IDX_ONE;
                end
            end else begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_read_unpack_fifo.sv
// -----------------------------------------------------------------------------
// Bench for ahb_read_unpack_fifo. Two instances (LSB-first and MSB-first,
// DATA_W = 32, DEPTH = 4) share one stimulus. A queue-based model predicts
// every output each cycle; literal stream/level expectations pin the model.
// -----------------------------------------------------------------------------
module tb_ahb_read_unpack_fifo;

    logic        tb_HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  status;
    logic        load_enable;
    logic [31:0] HRDATA;
    logic        shift_enable;
    logic        clear;

    logic [7:0]  le_data_in,  be_data_in;
    logic        le_data_valid, be_data_valid;
    logic        le_full, be_full, le_empty, be_empty;
    logic [2:0]  le_level, be_level;
    logic        le_overflow, be_overflow;
    logic        le_complete, be_complete;

    ahb_read_unpack_fifo #(.DATA_W(32), .DEPTH(4), .BYTE_ORDER(0)) dut_le (
        .HCLK(tb_HCLK), .HRESETn(HRESETn), .status(status), .load_enable(load_enable),
        .HRDATA(HRDATA), .shift_enable(shift_enable), .clear(clear),
        .data_in(le_data_in), .data_valid(le_data_valid), .full(le_full),
        .empty(le_empty), .level(le_level), .overflow(le_overflow),
        .transfer_data_complete_r(le_complete)
    );

    ahb_read_unpack_fifo #(.DATA_W(32), .DEPTH(4), .BYTE_ORDER(1)) dut_be (
        .HCLK(tb_HCLK), .HRESETn(HRESETn), .status(status), .load_enable(load_enable),
        .HRDATA(HRDATA), .shift_enable(shift_enable), .clear(clear),
        .data_in(be_data_in), .data_valid(be_data_valid), .full(be_full),
        .empty(be_empty), .level(be_level), .overflow(be_overflow),
        .transfer_data_complete_r(be_complete)
    );

    always #5 tb_HCLK = ~tb_HCLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_q[$];
    int          m_bidx  = 0;
    logic [7:0]  m_dle   = 8'h00;
    logic [7:0]  m_dbe   = 8'h00;
    logic        m_valid = 1'b0;
    logic        m_ovf   = 1'b0;
    logic        m_cmp   = 1'b0;

    // Byte number k (0 = first out) of a 4-byte word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k, input int msb_first);
        int pos;
        pos = msb_first ? (3 - k) : k;
        return 8'((w / (32'd1 << (8 * pos))) % 32'd256);
    endfunction

    task automatic model_flush();
        m_q.delete();
        m_bidx  = 0;
        m_dle   = 8'h00;
        m_dbe   = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_cmp   = 1'b0;
    endtask

    initial begin
        bit sh, pp, ld;
        forever begin
            @(posedge tb_HCLK or negedge HRESETn);
            if (!HRESETn || clear) begin
                model_flush();
            end else begin
                sh      = shift_enable && status == 2'b10 && m_q.size() != 0;
                pp      = sh && m_bidx == 3;
                ld      = load_enable && (m_q.size() < 4 || pp);
                m_cmp   = pp && m_q.size() == 1 && !ld;
                m_valid = sh;
                if (sh) begin
                    m_dle = byte_of(m_q[0], m_bidx, 0);
                    m_dbe = byte_of(m_q[0], m_bidx, 1);
                end
                if (pp) begin
                    void'(m_q.pop_front());
                    m_bidx = 0;
                end else if (sh) begin
                    m_bidx++;
                end
                if (ld) m_q.push_back(HRDATA);
                if (load_enable && !ld) m_ovf = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare + stream logs ----------------
    logic [127:0] log_le = '0;
    logic [127:0] log_be = '0;
    logic [63:0]  lvl_log = '0;
    int           cnt_le = 0, pulses_le = 0, pulses_be = 0;

    task automatic reset_logs();
        log_le = '0; log_be = '0; lvl_log = '0;
        cnt_le = 0; pulses_le = 0; pulses_be = 0;
    endtask

    initial begin
        logic [2:0] m_lvl;
        forever begin
            @(negedge tb_HCLK);
            m_lvl = 3'(m_q.size());
            chk("le_data_in",  128'(le_data_in),  128'(m_dle));
            chk("be_data_in",  128'(be_data_in),  128'(m_dbe));
            chk("le_valid",    128'(le_data_valid), 128'(m_valid));
            chk("be_valid",    128'(be_data_valid), 128'(m_valid));
            chk("le_level",    128'(le_level),    128'(m_lvl));
            chk("be_level",    128'(be_level),    128'(m_lvl));
            chk("le_full",     128'(le_full),     128'(m_lvl == 3'd4));
            chk("be_full",     128'(be_full),     128'(m_lvl == 3'd4));
            chk("le_empty",    128'(le_empty),    128'(m_lvl == 3'd0));
            chk("be_empty",    128'(be_empty),    128'(m_lvl == 3'd0));
            chk("le_overflow", 128'(le_overflow), 128'(m_ovf));
            chk("be_overflow", 128'(be_overflow), 128'(m_ovf));
            chk("le_complete", 128'(le_complete), 128'(m_cmp));
            chk("be_complete", 128'(be_complete), 128'(m_cmp));
            if (le_data_valid) begin
                log_le  = {log_le[119:0], le_data_in};
                lvl_log = {lvl_log[59:0], 1'b0, le_level};
                cnt_le++;
            end
            if (be_data_valid) log_be = {log_be[119:0], be_data_in};
            if (le_complete) pulses_le++;
            if (be_complete) pulses_be++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic le, input logic [31:0] d, input logic se,
                        input logic [1:0] st, input logic cl);
        load_enable = le; HRDATA = d; shift_enable = se; status = st; clear = cl;
        @(negedge tb_HCLK);
        #1;
    endtask

    task automatic load(input logic [31:0] d);  step(1'b1, d, 1'b0, 2'b10, 1'b0); endtask
    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 2'b10, 1'b0);
    endtask
    task automatic idle();  step(1'b0, 32'h0, 1'b0, 2'b10, 1'b0); endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_data_in"}, 128'(le_data_in), 128'h00);
        chk({nm, "_be_data"}, 128'(be_data_in), 128'h00);
        chk({nm, "_valid"},   128'(le_data_valid), 128'h0);
        chk({nm, "_level"},   128'(le_level), 128'h0);
        chk({nm, "_empty"},   128'(le_empty), 128'h1);
        chk({nm, "_full"},    128'(le_full), 128'h0);
        chk({nm, "_ovf"},     128'(le_overflow), 128'h0);
        chk({nm, "_cmp"},     128'(le_complete), 128'h0);
    endtask

    logic [31:0] wrap_w [6] = '{32'h01234567, 32'h89ABCDEF, 32'h02468ACE,
                                32'h13579BDF, 32'hFEDCBA98, 32'h76543210};

    initial begin
        HRESETn = 1'b0; load_enable = 1'b0; HRDATA = 32'h0;
        shift_enable = 1'b0; status = 2'b00; clear = 1'b0;

        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge tb_HCLK);
            #1;
            check_reset_outputs("rst");
        end
        HRESETn = 1'b1;

        // Basic unpack
        reset_logs();
        load(32'h12326485);
        chk("s1_level_after_load", 128'(le_level), 128'h1);
        shifts(4);
        idle();
        chk("s1_le_stream", log_le, 128'h85643212);
        chk("s1_be_stream", log_be, 128'h12326485);
        chk("s1_count", 128'(cnt_le), 128'd4);
        chk("s1_pulses", 128'(pulses_le), 128'd1);
        chk("s1_empty", 128'(le_empty), 128'h1);

        // Stall mid-word after the second byte
        reset_logs();
        load(32'h12326485);
        shifts(2);
        step(1'b0, 32'h0, 1'b1, 2'b00, 1'b0);
        chk("s2_stall_hold", 128'(le_data_in), 128'h64);
        chk("s2_stall_valid", 128'(le_data_valid), 128'h0);
        step(1'b0, 32'h0, 1'b1, 2'b00, 1'b0);
        chk("s2_stall_hold2", 128'(le_data_in), 128'h64);
        shifts(2);
        idle();
        chk("s2_le_stream", log_le, 128'h85643212);
        chk("s2_count", 128'(cnt_le), 128'd4);

        // Multi-word, both byte orders
        reset_logs();
        load(32'h13492F80);
        load(32'hA1B2C3D4);
        lvl_log = {lvl_log[59:0], 1'b0, le_level};
        shifts(8);
        idle();
        chk("s3_be_stream", log_be, 128'h13492F80A1B2C3D4);
        chk("s3_le_stream", log_le, 128'h802F4913D4C3B2A1);
        chk("s3_levels", 128'(lvl_log), 128'h222211110);
        chk("s3_pulses_be", 128'(pulses_be), 128'd1);

        // Full and overflow
        reset_logs();
        load(32'h03020100); load(32'h07060504); load(32'h0B0A0908); load(32'h0F0E0D0C);
        chk("s4_full", 128'(le_full), 128'h1);
        chk("s4_no_ovf_yet", 128'(le_overflow), 128'h0);
        load(32'hDEADBEEF);
        chk("s4_ovf", 128'(le_overflow), 128'h1);
        chk("s4_level", 128'(le_level), 128'h4);
        shifts(16);
        idle();
        chk("s4_le_stream", log_le, 128'h000102030405060708090A0B0C0D0E0F);
        chk("s4_be_stream", log_be, 128'h03020100070605040B0A09080F0E0D0C);
        chk("s4_count", 128'(cnt_le), 128'd16);
        step(1'b0, 32'h0, 1'b0, 2'b10, 1'b1);
        chk("s4_clear_ovf", 128'(le_overflow), 128'h0);

        // Load + pop while full
        reset_logs();
        load(32'hA0A1A2A3); load(32'hB0B1B2B3); load(32'hC0C1C2C3); load(32'hD0D1D2D3);
        shifts(3);
        step(1'b1, 32'h44332211, 1'b1, 2'b10, 1'b0);
        chk("s4b_level", 128'(le_level), 128'h4);
        chk("s4b_full", 128'(le_full), 128'h1);
        chk("s4b_ovf", 128'(le_overflow), 128'h0);
        shifts(16);
        idle();
        chk("s4b_le_stream", log_le, 128'hB3B2B1B0C3C2C1C0D3D2D1D011223344);
        chk("s4b_count", 128'(cnt_le), 128'd20);

        // Six words through both pointers' wrap
        reset_logs();
        for (int i = 0; i < 4; i++) load(wrap_w[i]);
        shifts(4);
        load(wrap_w[4]);
        shifts(4);
        load(wrap_w[5]);
        shifts(16);
        idle();
        chk("s5_le_stream", log_le, 128'hCE8A4602DF9B571398BADCFE10325476);
        chk("s5_count", 128'(cnt_le), 128'd24);

        // Clear mid-word with a concurrent load, after an overflow
        load(32'hCAFEF00D); load(32'h1); load(32'h2); load(32'h3); load(32'h4);
        shifts(2);
        chk("s5_pre_clear_data", 128'(le_data_in), 128'hF0);
        reset_logs();
        step(1'b1, 32'h0BADBEEF, 1'b1, 2'b10, 1'b1);
        check_reset_outputs("clr");
        idle();
        chk("clr_load_discarded", 128'(le_level), 128'h0);
        chk("clr_no_pulse", 128'(pulses_le), 128'd0);

        // Asynchronous reset between edges with 2 words queued
        load(32'h11223344);
        load(32'h55667788);
        shifts(1);
        chk("s6_before_reset", 128'(le_data_in), 128'h44);
        @(posedge tb_HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge tb_HCLK);
        #1;
        HRESETn = 1'b1;
        reset_logs();
        load(32'h12326485);
        shifts(4);
        idle();
        chk("s6_le_stream", log_le, 128'h85643212);
        chk("s6_count", 128'(cnt_le), 128'd4);
        chk("s6_pulses", 128'(pulses_le), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_read_unpack_fifo.md
Name: ahb_read_unpack_fifo

Overview:
- Parametrised read-side buffer between the AHB master read path and the pixel datapath.
- Stores up to DEPTH bus words captured from HRDATA and unpacks them into a byte stream on data_in, one byte per qualified shift.
- Generalises the single-word read FIFO with:
  - configurable bus width, depth and byte order;
  - full/empty/level flags, overflow detection and synchronous flush.

Parameters:
- DATA_W, 32, bus word width in bits; a multiple of 8, at least 16. BYTES = DATA_W/8.
- DEPTH, 4, word storage depth; a power of 2, at least 2.
- BYTE_ORDER, 0, 0 = least-significant byte first; 1 = most-significant byte first.

Ports:
- HCLK  in  1  system clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- status  in  2  transfer status; 2'b10 = consumer ready, any other value stalls shifting.
- load_enable  in  1  capture HRDATA into the tail slot this cycle.
- HRDATA  in  DATA_W  AHB read data word.
- shift_enable  in  1  request the next byte.
- clear  in  1  synchronous flush.
- data_in  out  8  registered output byte.
- data_valid  out  1  one-cycle pulse; data_in was updated this cycle.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- level  out  clog2(DEPTH)+1  stored word count, including a partially consumed head word.
- overflow  out  1  sticky: a load was dropped.
- transfer_data_complete_r  out  1  one-cycle pulse when the FIFO drains to empty.

Behaviour:
- Reset: HRESETn low asynchronously forces the following, regardless of any operation in progress:
  - data_in = 8'h00, data_valid = 0, full = 0, empty = 1, level = 0, overflow = 0, transfer_data_complete_r = 0;
  - wr_ptr, rd_ptr and byte_idx = 0.
  - Storage contents are don't-care.
- Qualified shift: shift = shift_enable && status == 2'b10 && !empty, evaluated on pre-edge state.
  - Shift requested while empty: ignored, data_in holds, data_valid = 0.
- Pop: pop = shift && byte_idx == BYTES-1.
- Qualified load: load = load_enable && (!full || pop).
  - A load while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set and stays 1 until clear or reset.
- On shift:
  - data_in <= byte byte_idx of the head word, data_valid <= 1.
  - BYTE_ORDER = 0: byte k = bits [8k+7:8k]. BYTE_ORDER = 1: byte k = bits [DATA_W-1-8k -: 8].
  - byte_idx increments; on pop it wraps to 0 and rd_ptr advances.
- No shift: data_in holds its value, data_valid <= 0.
- On load: the slot at wr_ptr <= HRDATA, wr_ptr advances.
- Pointer wrap: wr_ptr and rd_ptr wrap modulo DEPTH.
- Level: level <= level + load - pop. full and empty are registered and consistent with the new level in the same cycle.
- Latency from load to output:
  - A word loaded at edge k is shiftable at edge k+1 at the earliest.
  - Its first byte appears on data_in after edge k+1.
  - A load into an empty FIFO is never shifted in the same cycle.
- Simultaneous load and pop at any level: both take effect and level is unchanged.
- Stall: status != 2'b10 holds byte_idx, pointers and data_in. Shifting resumes at the same byte.
- transfer_data_complete_r: 1 for exactly one cycle after the edge on which pop occurs with level == 1 and no load. Otherwise 0.
- clear (synchronous):
  - Takes priority over load and shift.
  - Resets pointers, byte_idx, level (0), overflow, data_in (8'h00) and data_valid (0).
  - Sets empty = 1, full = 0.
  - No complete pulse is generated.
- Loads are never throttled by status; only shifting depends on status.

Test Plan:
- Reset and basic unpack:
  - Stimulus: hold HRESETn low 3 cycles; then load 32'h12326485 with BYTE_ORDER = 0; then shift_enable = 1 with status = 2'b10.
  - Response: all outputs at reset values during reset; then data_in = 85, 64, 32, 12 on consecutive cycles with data_valid high; transfer_data_complete_r pulses with the 12 byte; empty = 1 afterwards.
- Stall mid-word:
  - Stimulus: same word; status = 2'b00 for 2 cycles after the second byte.
  - Response: data_in holds 64 and data_valid = 0 during the stall; on resume the stream continues with 32, 12, with no byte skipped or repeated.
- Big-endian and multi-word:
  - Stimulus: BYTE_ORDER = 1, DATA_W = 32; load 32'h13492F80 and 32'hA1B2C3D4 back-to-back.
  - Response: data_in = 13, 49, 2F, 80, A1, B2, C3, D4; a single complete pulse after D4; level reads 2, 2, 2, 2, 1, 1, 1, 1, 0 across the stream.
- Full and overflow:
  - Stimulus: DEPTH = 4; 5 loads with no shifting.
  - Response: full = 1 after the 4th load; the 5th word is dropped and overflow = 1; shifting returns only the first 4 words.
  - Follow-on: with full = 1, load and pop in the same cycle; level stays 4 and overflow is not newly set.
- Wrap and clear:
  - Stimulus: stream 6 words through DEPTH = 4 so both pointers wrap; then assert clear mid-word together with load_enable.
  - Response: byte order across the wrap is correct; after clear, level = 0, empty = 1, overflow = 0, data_in = 00, no complete pulse, and the concurrent load is discarded.
- Reset mid-operation:
  - Stimulus: pulse HRESETn low asynchronously between edges while 2 words are queued.
  - Response: outputs go to reset values immediately, without waiting for a clock edge; the next load/shift sequence behaves as from power-up.
